// File: rtl/hdc_csr_host_sequencer_pkg.sv
// Shared types and default constants for the HDC CSR host sequencer.
// Contents:
//   state_e          : sequencer FSM states
//   ADDR_*_DEF       : default CSR register addresses of the accelerator slave
//   ST_* / IN_*      : bit positions inside the STATUS and INPUT registers
package hdc_host_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_START = 3'd1,
    POLL_IN  = 3'd2,
    WR_INPUT = 3'd3,
    POLL_OUT = 3'd4,
    RD_OUT   = 3'd5,
    RESULT   = 3'd6
  } state_e;

  localparam logic [31:0] ADDR_START_DEF  = 32'h0;
  localparam logic [31:0] ADDR_STATUS_DEF = 32'h4;
  localparam logic [31:0] ADDR_INPUT_DEF  = 32'h8;
  localparam logic [31:0] ADDR_OUTPUT_DEF = 32'hC;

  localparam int ST_IN_RDY_DEF   = 0;
  localparam int ST_OUT_VLD_DEF  = 1;
  localparam int IN_VLD_BIT_DEF  = 8;
  localparam int IN_DONE_BIT_DEF = 9;

endpackage

// File: rtl/hdc_csr_host_sequencer_txn.sv
// csr_txn_engine: runs exactly one CSR request/response transaction at a time.
// Handshake: a request beat transfers on the rising edge where
// csr_req_valid_o && csr_req_ready_i; the response beat transfers on the edge
// where csr_rsp_valid_i && csr_rsp_ready_o. Request fields are registered and
// held stable while csr_req_valid_o is high; rsp_ready is only raised after the
// request has been accepted, so any response arriving outside that window
// (including one left over from before a reset) is ignored.
// Ports:
//   start_i/addr_i/wdata_i/wen_i : launch a transaction (sampled only when idle)
//   busy_o                       : transaction outstanding
//   done_o/rdata_o               : response handshake this cycle, read data
//   csr_*                        : CSR master port
module csr_txn_engine #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          wen_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] rdata_o,
  output logic [AW-1:0] csr_addr_o,
  output logic [DW-1:0] csr_wr_data_o,
  output logic          csr_wr_en_o,
  output logic          csr_req_valid_o,
  input  logic          csr_req_ready_i,
  input  logic [DW-1:0] csr_rd_data_i,
  input  logic          csr_rsp_valid_i,
  output logic          csr_rsp_ready_o
);

  logic          req_q;
  logic          wait_q;
  logic          wen_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q  <= 1'b0;
      wait_q <= 1'b0;
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (req_q) begin
      if (csr_req_ready_i) begin
        req_q  <= 1'b0;
        wait_q <= 1'b1;
      end
    end else if (wait_q) begin
      if (csr_rsp_valid_i) wait_q <= 1'b0;
    end else if (start_i) begin
      req_q  <= 1'b1;
      wen_q  <= wen_i;
      addr_q <= addr_i;
      data_q <= wdata_i;
    end
  end

  assign busy_o          = req_q | wait_q;
  assign done_o          = wait_q & csr_rsp_valid_i;
  assign rdata_o         = csr_rd_data_i;
  assign csr_addr_o      = addr_q;
  assign csr_wr_data_o   = data_q;
  assign csr_wr_en_o     = wen_q;
  assign csr_req_valid_o = req_q;
  assign csr_rsp_ready_o = wait_q;

endmodule

// File: rtl/hdc_csr_host_sequencer.sv
// hdc_csr_host_sequencer: host-side CSR initiator that runs one classification
// job on the accelerator: write START, stream samples into INPUT whenever
// STATUS reports in_ready, poll STATUS for output_valid, read OUTPUT, and hand
// the class to the result sink.
// Ports:
//   job_start_i/busy_o                     : job launch / job in progress
//   smp_valid_i/smp_ready_o/smp_value_i/smp_last_i : sample source (ready pulses
//                                            for one cycle when the INPUT write
//                                            carrying that sample is issued)
//   res_valid_o/res_ready_i/res_class_o/res_err_o  : result sink
//   sample_cnt_o                           : INPUT writes completed this job
//   csr_*                                  : CSR master port to the accelerator
//   dbg_state_o                            : current FSM state
module hdc_csr_host_sequencer
  import hdc_host_pkg::*;
#(
  parameter int                        CSR_WIDTH      = 32,
  parameter int                        CSR_ADDR_WIDTH = 32,
  parameter logic [CSR_ADDR_WIDTH-1:0] ADDR_START     = CSR_ADDR_WIDTH'(ADDR_START_DEF),
  parameter logic [CSR_ADDR_WIDTH-1:0] ADDR_STATUS    = CSR_ADDR_WIDTH'(ADDR_STATUS_DEF),
  parameter logic [CSR_ADDR_WIDTH-1:0] ADDR_INPUT     = CSR_ADDR_WIDTH'(ADDR_INPUT_DEF),
  parameter logic [CSR_ADDR_WIDTH-1:0] ADDR_OUTPUT    = CSR_ADDR_WIDTH'(ADDR_OUTPUT_DEF),
  parameter int                        ST_IN_RDY      = ST_IN_RDY_DEF,
  parameter int                        ST_OUT_VLD     = ST_OUT_VLD_DEF,
  parameter int                        IN_VLD_BIT     = IN_VLD_BIT_DEF,
  parameter int                        IN_DONE_BIT    = IN_DONE_BIT_DEF,
  parameter int                        POLL_LIMIT     = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      job_start_i,
  output logic                      busy_o,
  input  logic                      smp_valid_i,
  output logic                      smp_ready_o,
  input  logic [5:0]                smp_value_i,
  input  logic                      smp_last_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [4:0]                res_class_o,
  output logic                      res_err_o,
  output logic [15:0]               sample_cnt_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
  output logic [CSR_WIDTH-1:0]      csr_wr_data_o,
  output logic                      csr_wr_en_o,
  output logic                      csr_req_valid_o,
  input  logic                      csr_req_ready_i,
  input  logic [CSR_WIDTH-1:0]      csr_rd_data_i,
  input  logic                      csr_rsp_valid_i,
  output logic                      csr_rsp_ready_o,
  output state_e                    dbg_state_o
);

  localparam int PCW = $clog2(POLL_LIMIT + 1);

  state_e                    state_q, state_d;
  logic [PCW-1:0]            poll_cnt_q, poll_cnt_d;
  logic                      last_q;
  logic [4:0]                res_class_q, res_class_d;
  logic                      res_err_q, res_err_d;
  logic [15:0]               sample_cnt_q;

  logic                      eng_start, eng_wen, eng_busy, eng_done;
  logic [CSR_ADDR_WIDTH-1:0] eng_addr;
  logic [CSR_WIDTH-1:0]      eng_wdata, eng_rdata, in_word;
  logic                      job_accept, cnt_inc, res_load, last_load, poll_last;
  logic                      unused_rdata;

  csr_txn_engine #(.AW(CSR_ADDR_WIDTH), .DW(CSR_WIDTH)) u_txn (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .start_i         (eng_start),
    .addr_i          (eng_addr),
    .wdata_i         (eng_wdata),
    .wen_i           (eng_wen),
    .busy_o          (eng_busy),
    .done_o          (eng_done),
    .rdata_o         (eng_rdata),
    .csr_addr_o      (csr_addr_o),
    .csr_wr_data_o   (csr_wr_data_o),
    .csr_wr_en_o     (csr_wr_en_o),
    .csr_req_valid_o (csr_req_valid_o),
    .csr_req_ready_i (csr_req_ready_i),
    .csr_rd_data_i   (csr_rd_data_i),
    .csr_rsp_valid_i (csr_rsp_valid_i),
    .csr_rsp_ready_o (csr_rsp_ready_o)
  );

  // Only a handful of read-data bits are meaningful to the sequencer.
  assign unused_rdata = ^eng_rdata;

  // INPUT register word for the sample currently offered by the source.
  always_comb begin
    in_word              = '0;
    in_word[5:0]         = smp_value_i;
    in_word[IN_VLD_BIT]  = 1'b1;
    in_word[IN_DONE_BIT] = smp_last_i;
  end

  // The counter holds the number of consecutive failed polls so far; the poll
  // that would make it reach POLL_LIMIT ends the job with an error instead.
  assign poll_last = (poll_cnt_q == PCW'(POLL_LIMIT - 1));

  always_comb begin
    state_d     = state_q;
    poll_cnt_d  = poll_cnt_q;
    eng_start   = 1'b0;
    eng_addr    = ADDR_STATUS;
    eng_wdata   = '0;
    eng_wen     = 1'b0;
    smp_ready_o = 1'b0;
    job_accept  = 1'b0;
    cnt_inc     = 1'b0;
    res_load    = 1'b0;
    res_class_d = '0;
    res_err_d   = 1'b0;
    last_load   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (job_start_i) begin
          job_accept = 1'b1;
          poll_cnt_d = '0;
          state_d    = WR_START;
        end
      end
      WR_START: begin
        eng_addr  = ADDR_START;
        eng_wdata = CSR_WIDTH'(1);
        eng_wen   = 1'b1;
        eng_start = !eng_busy;
        if (eng_done) state_d = POLL_IN;
      end
      POLL_IN: begin
        eng_start = !eng_busy;
        if (eng_done) begin
          if (eng_rdata[ST_IN_RDY]) begin
            // Accelerator is ready; an empty source just means poll again.
            poll_cnt_d = '0;
            if (smp_valid_i) state_d = WR_INPUT;
          end else if (poll_last) begin
            poll_cnt_d = '0;
            res_load   = 1'b1;
            res_err_d  = 1'b1;
            state_d    = RESULT;
          end else begin
            poll_cnt_d = poll_cnt_q + PCW'(1);
          end
        end
      end
      WR_INPUT: begin
        eng_addr    = ADDR_INPUT;
        eng_wdata   = in_word;
        eng_wen     = 1'b1;
        eng_start   = !eng_busy && smp_valid_i;
        smp_ready_o = eng_start;
        last_load   = eng_start;
        if (eng_done) begin
          cnt_inc = 1'b1;
          state_d = last_q ? POLL_OUT : POLL_IN;
        end
      end
      POLL_OUT: begin
        eng_start = !eng_busy;
        if (eng_done) begin
          if (eng_rdata[ST_OUT_VLD]) begin
            poll_cnt_d = '0;
            state_d    = RD_OUT;
          end else if (poll_last) begin
            poll_cnt_d = '0;
            res_load   = 1'b1;
            res_err_d  = 1'b1;
            state_d    = RESULT;
          end else begin
            poll_cnt_d = poll_cnt_q + PCW'(1);
          end
        end
      end
      RD_OUT: begin
        eng_addr  = ADDR_OUTPUT;
        eng_start = !eng_busy;
        if (eng_done) begin
          res_load    = 1'b1;
          res_class_d = eng_rdata[4:0];
          state_d     = RESULT;
        end
      end
      RESULT: begin
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      poll_cnt_q   <= '0;
      last_q       <= 1'b0;
      res_class_q  <= '0;
      res_err_q    <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      if (last_load) last_q <= smp_last_i;
      if (job_accept) begin
        sample_cnt_q <= '0;
        res_class_q  <= '0;
        res_err_q    <= 1'b0;
      end else begin
        if (cnt_inc && sample_cnt_q != 16'hFFFF) sample_cnt_q <= sample_cnt_q + 16'd1;
        if (res_load) begin
          res_class_q <= res_class_d;
          res_err_q   <= res_err_d;
        end
      end
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign res_valid_o  = (state_q == RESULT);
  assign res_class_o  = res_class_q;
  assign res_err_o    = res_err_q;
  assign sample_cnt_o = sample_cnt_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_hdc_csr_host_sequencer.sv
// Bench for hdc_csr_host_sequencer: a CSR slave model that checks every
// accepted request against an expected-transaction queue, a result monitor
// that checks every result handshake against an expected-result queue, and
// directed jobs whose expectations are written out by hand.
module tb_hdc_csr_host_sequencer;
  import hdc_host_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int PL = 12;
  localparam int TW = 65;   // {wen, addr, wdata}
  localparam int RW = 22;   // {err, class, sample_cnt}

  localparam logic [31:0] A_START  = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_INPUT  = 32'h8;
  localparam logic [31:0] A_OUTPUT = 32'hC;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          job_start_i = 1'b0;
  logic          busy_o;
  logic          smp_valid_i = 1'b0;
  logic          smp_ready_o;
  logic [5:0]    smp_value_i = '0;
  logic          smp_last_i = 1'b0;
  logic          res_valid_o;
  logic          res_ready_i = 1'b0;
  logic [4:0]    res_class_o;
  logic          res_err_o;
  logic [15:0]   sample_cnt_o;
  logic [AW-1:0] csr_addr_o;
  logic [DW-1:0] csr_wr_data_o;
  logic          csr_wr_en_o;
  logic          csr_req_valid_o;
  logic          csr_req_ready_i;
  logic [DW-1:0] csr_rd_data_i;
  logic          csr_rsp_valid_i;
  logic          csr_rsp_ready_o;
  state_e        dbg_state;

  always #5 clk = ~clk;

  hdc_csr_host_sequencer #(.POLL_LIMIT(PL)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .job_start_i     (job_start_i),
    .busy_o          (busy_o),
    .smp_valid_i     (smp_valid_i),
    .smp_ready_o     (smp_ready_o),
    .smp_value_i     (smp_value_i),
    .smp_last_i      (smp_last_i),
    .res_valid_o     (res_valid_o),
    .res_ready_i     (res_ready_i),
    .res_class_o     (res_class_o),
    .res_err_o       (res_err_o),
    .sample_cnt_o    (sample_cnt_o),
    .csr_addr_o      (csr_addr_o),
    .csr_wr_data_o   (csr_wr_data_o),
    .csr_wr_en_o     (csr_wr_en_o),
    .csr_req_valid_o (csr_req_valid_o),
    .csr_req_ready_i (csr_req_ready_i),
    .csr_rd_data_i   (csr_rd_data_i),
    .csr_rsp_valid_i (csr_rsp_valid_i),
    .csr_rsp_ready_o (csr_rsp_ready_o),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [TW-1:0] exp_q[$];
  logic [RW-1:0] res_exp_q[$];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic push_rd(input logic [31:0] a);
    exp_q.push_back({1'b0, a, 32'h0});
  endtask

  // ---------------- CSR slave model + request monitor ----------------
  int            req_wait = 0;      // cycles req_ready stays low per request
  int            status_fail = 0;   // STATUS reads still to answer with 0
  logic [1:0]    status_val = 2'b11;
  logic [4:0]    out_class = '0;
  bit            hold_rsp = 0;
  bit            force_rsp = 0;
  bit            slave_pend = 0;
  logic [31:0]   slave_pdata = '0;
  int            slave_stall = 0;
  bit            slave_seen = 0;
  logic [TW-1:0] slave_first, slave_cur, slave_exp;

  initial begin
    csr_req_ready_i = 1'b0;
    csr_rsp_valid_i = 1'b0;
    csr_rd_data_i   = '0;
    forever begin
      @(negedge clk);
      csr_rsp_valid_i = 1'b0;
      if (force_rsp) begin
        csr_rsp_valid_i = 1'b1;
        csr_rd_data_i   = 32'h3;
      end else if (slave_pend && !hold_rsp) begin
        csr_rsp_valid_i = 1'b1;
        csr_rd_data_i   = slave_pdata;
        slave_pend      = 0;
      end
      csr_req_ready_i = 1'b0;
      if (rst_ni && csr_req_valid_o) begin
        slave_cur = {csr_wr_en_o, csr_addr_o, csr_wr_data_o};
        if (!slave_seen) begin
          slave_first = slave_cur;
          slave_seen  = 1;
        end
        if (slave_stall < req_wait) begin
          slave_stall++;
        end else begin
          csr_req_ready_i = 1'b1;
          if (req_wait > 0) check("req_stable", slave_cur, slave_first);
          slave_stall = 0;
          slave_seen  = 0;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_txn: got 0x%0h, want none", slave_cur);
          end else begin
            slave_exp = exp_q.pop_front();
            check("txn_wen_addr", slave_cur[64:32], slave_exp[64:32]);
            if (slave_exp[64]) check("txn_wdata", slave_cur[31:0], slave_exp[31:0]);
          end
          slave_pend = 1;
          if (csr_addr_o == A_STATUS) begin
            if (status_fail > 0) begin
              slave_pdata = 32'h0;
              status_fail--;
            end else begin
              slave_pdata = {30'h0, status_val};
            end
          end else if (csr_addr_o == A_OUTPUT) begin
            slave_pdata = {27'h0, out_class};
          end else begin
            slave_pdata = 32'hDEAD_BEEF;
          end
        end
      end
    end
  end

  // ---------------- result monitor ----------------
  always @(negedge clk) begin
    if (rst_ni && res_valid_o && res_ready_i) begin
      if (res_exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%0h, want none", {res_err_o, res_class_o});
      end else begin
        logic [RW-1:0] e;
        e = res_exp_q.pop_front();
        check("res_err_class", {res_err_o, res_class_o}, e[21:16]);
        check("res_sample_cnt", sample_cnt_o, e[15:0]);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_samples(input logic [5:0] v[$]);
    for (int i = 0; i < v.size(); i++) begin
      int t = 0;
      smp_valid_i = 1'b1;
      smp_value_i = v[i];
      smp_last_i  = (i == v.size() - 1);
      @(negedge clk);
      while (!smp_ready_o && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (!smp_ready_o) begin
        n_tests++;
        n_fail++;
        $display("FAIL smp_timeout: got no smp_ready for sample %0d, want ready", i);
        break;
      end
      @(posedge clk);
      #1;
    end
    smp_valid_i = 1'b0;
    smp_last_i  = 1'b0;
  endtask

  task automatic wait_result(input int hold, input bit poke);
    int         t = 0;
    logic [5:0] held;
    @(negedge clk);
    while (!res_valid_o && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (!res_valid_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL res_timeout: got res_valid 0, want 1");
      return;
    end
    held = {res_err_o, res_class_o};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1 job_start_i = poke && (i == 1);
      @(negedge clk);
      check("res_hold_valid", {res_valid_o, busy_o}, 2'b11);
      check("res_hold_stable", {res_err_o, res_class_o}, held);
    end
    @(posedge clk);
    #1 job_start_i = 1'b0;
    res_ready_i = 1'b1;
    @(posedge clk);
    #1 res_ready_i = 1'b0;
    @(negedge clk);
    check("res_done_idle", {busy_o, res_valid_o}, 2'b00);
  endtask

  task automatic run_job(input logic [5:0] v[$], input int hold, input bit poke);
    @(posedge clk);
    #1 job_start_i = 1'b1;
    @(posedge clk);
    #1 job_start_i = 1'b0;
    @(negedge clk);
    check("start_busy", busy_o, 1'b1);
    check("start_cnt_clear", sample_cnt_o, 16'd0);
    fork
      drive_samples(v);
      wait_result(hold, poke);
    join
    repeat (3) @(negedge clk);
    check("txn_drained", exp_q.size(), 0);
    check("res_drained", res_exp_q.size(), 0);
    check("idle_after", {busy_o, csr_req_valid_o, dbg_state}, {1'b0, 1'b0, IDLE});
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [5:0] s[$];
    int t;

    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy_o, smp_ready_o, res_valid_o, res_err_o, res_class_o}, 0);
    check("rst_csr", {csr_req_valid_o, csr_rsp_ready_o, csr_wr_en_o, csr_addr_o, csr_wr_data_o}, 0);
    check("rst_cnt_state", {sample_cnt_o, dbg_state}, {16'd0, IDLE});
    @(posedge clk);
    #1 rst_ni = 1'b1;

    // 1: zero-wait slave, three samples, status always ready
    out_class = 5'd7;
    push_wr(A_START, 32'h1);
    push_rd(A_STATUS); push_wr(A_INPUT, 32'h105);
    push_rd(A_STATUS); push_wr(A_INPUT, 32'h10C);
    push_rd(A_STATUS); push_wr(A_INPUT, 32'h33F);
    push_rd(A_STATUS); push_rd(A_OUTPUT);
    res_exp_q.push_back({1'b0, 5'd7, 16'd3});
    s = '{6'd5, 6'd12, 6'd63};
    run_job(s, 0, 0);

    // 2: slave stalls every request five cycles
    req_wait = 5;
    out_class = 5'd2;
    push_wr(A_START, 32'h1);
    push_rd(A_STATUS); push_wr(A_INPUT, 32'h103);
    push_rd(A_STATUS); push_wr(A_INPUT, 32'h309);
    push_rd(A_STATUS); push_rd(A_OUTPUT);
    res_exp_q.push_back({1'b0, 5'd2, 16'd2});
    s = '{6'd3, 6'd9};
    run_job(s, 0, 0);
    req_wait = 0;

    // 3: in_ready low for ten polls
    status_fail = 10;
    out_class = 5'd21;
    push_wr(A_START, 32'h1);
    for (int i = 0; i < 11; i++) push_rd(A_STATUS);
    push_wr(A_INPUT, 32'h321);
    push_rd(A_STATUS); push_rd(A_OUTPUT);
    res_exp_q.push_back({1'b0, 5'd21, 16'd1});
    s = '{6'd33};
    run_job(s, 0, 0);

    // 4: output_valid never set -> timeout after PL failing polls
    status_val = 2'b01;
    out_class = 5'd9;
    push_wr(A_START, 32'h1);
    push_rd(A_STATUS); push_wr(A_INPUT, 32'h32A);
    for (int i = 0; i < PL; i++) push_rd(A_STATUS);
    res_exp_q.push_back({1'b1, 5'd0, 16'd1});
    s = '{6'd42};
    run_job(s, 0, 0);
    status_val = 2'b11;

    // 5: sink stalls four cycles, job_start poked while busy
    out_class = 5'd30;
    push_wr(A_START, 32'h1);
    push_rd(A_STATUS); push_wr(A_INPUT, 32'h301);
    push_rd(A_STATUS); push_rd(A_OUTPUT);
    res_exp_q.push_back({1'b0, 5'd30, 16'd1});
    s = '{6'd1};
    run_job(s, 4, 1);

    // 6: reset while a response is outstanding, then a late response
    hold_rsp = 1;
    push_wr(A_START, 32'h1);
    @(posedge clk);
    #1 job_start_i = 1'b1;
    @(posedge clk);
    #1 job_start_i = 1'b0;
    t = 0;
    while (!slave_pend && t < 100) begin
      @(posedge clk);
      #1 t++;
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    #1 check("pre_rst_wait", {csr_rsp_ready_o, dbg_state}, {1'b1, WR_START});
    rst_ni = 1'b0;
    slave_pend = 0;
    hold_rsp = 0;
    #1;
    check("midrst_ctrl", {busy_o, smp_ready_o, res_valid_o, res_err_o, res_class_o, sample_cnt_o}, 0);
    check("midrst_csr", {csr_req_valid_o, csr_rsp_ready_o, csr_wr_en_o, csr_addr_o, csr_wr_data_o}, 0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    force_rsp = 1;
    @(posedge clk);
    #1 force_rsp = 0;
    @(negedge clk);
    check("late_rsp_ignored", {busy_o, csr_req_valid_o, csr_rsp_ready_o, dbg_state}, {3'b000, IDLE});
    check("late_rsp_drained", exp_q.size(), 0);

    // 7: next job after reset runs normally
    out_class = 5'd4;
    push_wr(A_START, 32'h1);
    push_rd(A_STATUS); push_wr(A_INPUT, 32'h311);
    push_rd(A_STATUS); push_rd(A_OUTPUT);
    res_exp_q.push_back({1'b0, 5'd4, 16'd1});
    s = '{6'd17};
    run_job(s, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, want $finish");
    $fatal(1, "watchdog");
  end

endmodule
